imem_fetch_sequencer: RTL and testbench

Sequences the combinational instruction memory: owns the fetch PC, drives the memory address each cycle, registers the returned word with its PC, and reports a valid/stall/redirect handshake to decode. It sits between the PC-update logic of the single-cycle core and the instruction memory. It is the only block allowed to drive the memory address. It stops fetching permanently on an address fault or an all-zero word, until reset.

---
 rtl/imem_fetch_sequencer_pkg.sv | 17 +
 rtl/imem_fetch_check.sv | 37 +++
 rtl/imem_fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its
// combinational fault/halt checker.
package imem_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [1:0]  CAUSE_NONE     = 2'b00;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE    = 2'b10;

    localparam logic [31:0] INSTR_ZERO     = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_check.sv
// Combinational classification of the word at the current fetch PC:
// address fault (with cause) and the all-zero halt word.
module imem_fetch_check
    import imem_fetch_sequencer_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic [31:0] pc_i,
    input  logic        imem_error_i,
    input  logic [31:0] imem_instr_i,
    output logic        fault_o,
    output logic [1:0]  cause_o,
    output logic        zero_o
);

    localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);

    logic misalign;
    logic outOfRange;

    assign misalign   = (pc_i[1:0] != 2'b00);
    assign outOfRange = (pc_i > LAST_WORD) || imem_error_i;

    // Misalignment takes precedence when both conditions hold.
    always_comb begin
        cause_o = CAUSE_NONE;
        if (misalign) begin
            cause_o = CAUSE_MISALIGN;
        end else if (outOfRange) begin
            cause_o = CAUSE_RANGE;
        end
    end

    assign fault_o = misalign || outOfRange;
    assign zero_o  = (imem_instr_i == INSTR_ZERO);

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Owns the fetch PC, drives the instruction memory address and registers the
// returned word for decode; stops permanently on a fault or zero word until reset.
module imem_fetch_sequencer
    import imem_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    input  logic        imem_error_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic [31:0] fault_pc_o,
    output logic        halt_o,
    output logic [31:0] fetch_count_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instrPc_q, instrPc_d;
    logic         fault_q, fault_d;
    logic [1:0]   cause_q, cause_d;
    logic [31:0]  faultPc_q, faultPc_d;
    logic         halt_q, halt_d;
    logic [31:0]  count_q, count_d;

    logic         chkFault;
    logic [1:0]   chkCause;
    logic         chkZero;

    imem_fetch_check #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_check (
        .pc_i         (pc_q),
        .imem_error_i (imem_error_i),
        .imem_instr_i (imem_instr_i),
        .fault_o      (chkFault),
        .cause_o      (chkCause),
        .zero_o       (chkZero)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        instrPc_d = instrPc_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        faultPc_d = faultPc_q;
        halt_d    = halt_q;
        count_d   = count_q;

        unique case (state_q)
            RUN: begin
                // Redirect outranks stall; the target is only checked once fetched.
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_i;
                    valid_d = 1'b0;
                end else if (stall_i) begin
                    valid_d = valid_q;
                end else if (chkFault) begin
                    state_d   = FAULT;
                    fault_d   = 1'b1;
                    cause_d   = chkCause;
                    faultPc_d = pc_q;
                    valid_d   = 1'b0;
                end else if (chkZero) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    instr_d   = imem_instr_i;
                    instrPc_d = pc_q;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    count_d   = count_q + 32'd1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            instr_q   <= 32'h0;
            instrPc_q <= 32'h0;
            fault_q   <= 1'b0;
            cause_q   <= CAUSE_NONE;
            faultPc_q <= 32'h0;
            halt_q    <= 1'b0;
            count_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            instrPc_q <= instrPc_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
            faultPc_q <= faultPc_d;
            halt_q    <= halt_d;
            count_q   <= count_d;
        end
    end

    assign imem_pc_o     = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instrPc_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign fault_pc_o    = faultPc_q;
    assign halt_o        = halt_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Table-driven directed vectors plus randomized traffic checked against a
// behavioural model of the fetch sequencer.
module tb_imem_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] W0 = 32'h1230_8093;
    localparam logic [31:0] W1 = 32'h0020_8133;
    localparam logic [31:0] W4 = 32'h0050_0093;
    localparam logic [31:0] WL = 32'h0FF0_0113;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] fpc;
        logic        halt;
        logic [31:0] count;
    } obs_t;

    typedef struct {
        logic        rstn;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        err;
        obs_t        exp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] imem_pc_o;
    logic [31:0] imem_instr_i;
    logic        imem_error_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic [31:0] fault_pc_o;
    logic        halt_o;
    logic [31:0] fetch_count_o;

    logic [31:0] mem [0:255];
    obs_t        m;
    vec_t        tbl[$];
    int          vectors = 0;
    int          miscompares = 0;

    imem_fetch_sequencer #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (1024)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_pc_o        (imem_pc_o),
        .imem_instr_i     (imem_instr_i),
        .imem_error_i     (imem_error_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .fault_o          (fault_o),
        .fault_cause_o    (fault_cause_o),
        .fault_pc_o       (fault_pc_o),
        .halt_o           (halt_o),
        .fetch_count_o    (fetch_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory answers combinationally at whatever address the sequencer drives.
    assign imem_instr_i = (imem_pc_o < 32'd1024) ? mem[imem_pc_o[9:2]] : 32'hDEAD_BEEF;

    function automatic logic [31:0] memRead(input logic [31:0] addr);
        return (addr < 32'd1024) ? mem[addr[9:2]] : 32'hDEAD_BEEF;
    endfunction

    function automatic obs_t mkObs(input logic [31:0] pc, input logic valid,
                                   input logic [31:0] instr, input logic [31:0] ipc,
                                   input logic fault, input logic [1:0] cause,
                                   input logic [31:0] fpc, input logic halt,
                                   input logic [31:0] count);
        obs_t o;
        o.pc = pc; o.valid = valid; o.instr = instr; o.ipc = ipc;
        o.fault = fault; o.cause = cause; o.fpc = fpc; o.halt = halt; o.count = count;
        return o;
    endfunction

    function automatic vec_t mkVec(input logic rstn, input logic stall, input logic redir,
                                   input logic [31:0] rpc, input logic err, input obs_t e);
        vec_t v;
        v.rstn = rstn; v.stall = stall; v.redir = redir; v.rpc = rpc; v.err = err; v.exp = e;
        return v;
    endfunction

    // Reference behaviour: stopped blocks ignore everything but reset; otherwise
    // redirect, stall, fault, zero word and normal fetch in that order.
    task automatic modelStep(input logic rstn, input logic stall, input logic redir,
                             input logic [31:0] rpc, input logic err);
        logic [31:0] word;
        word = memRead(m.pc);
        if (!rstn) begin
            m = mkObs(RESET_PC, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        end else if (m.fault || m.halt) begin
            m.valid = 1'b0;
        end else if (redir) begin
            m.pc = rpc;
            m.valid = 1'b0;
        end else if (!stall) begin
            if ((m.pc % 4) != 0) begin
                m.fault = 1'b1; m.cause = 2'b01; m.fpc = m.pc; m.valid = 1'b0;
            end else if (m.pc > 32'd1020 || err) begin
                m.fault = 1'b1; m.cause = 2'b10; m.fpc = m.pc; m.valid = 1'b0;
            end else if (word == 32'h0) begin
                m.halt = 1'b1; m.valid = 1'b0;
            end else begin
                m.instr = word; m.ipc = m.pc; m.valid = 1'b1;
                m.pc = m.pc + 32'd4; m.count = m.count + 32'd1;
            end
        end
    endtask

    task automatic applyStimulus(input logic rstn, input logic stall, input logic redir,
                                 input logic [31:0] rpc, input logic err);
        @(negedge clk_i);
        rst_n_i = rstn;
        stall_i = stall;
        redirect_valid_i = redir;
        redirect_pc_i = rpc;
        imem_error_i = err;
        @(posedge clk_i);
        modelStep(rstn, stall, redir, rpc, err);
        #1;
    endtask

    task automatic cmpField(input string tag, input string name,
                            input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s %s: got %h, expected %h", tag, name, got, exp);
        end
    endtask

    task automatic checkOutput(input obs_t e, input string tag);
        vectors++;
        cmpField(tag, "imem_pc",     imem_pc_o,             e.pc);
        cmpField(tag, "instr_valid", 32'(instr_valid_o),    32'(e.valid));
        cmpField(tag, "instr",       instr_o,               e.instr);
        cmpField(tag, "instr_pc",    instr_pc_o,            e.ipc);
        cmpField(tag, "fault",       32'(fault_o),          32'(e.fault));
        cmpField(tag, "fault_cause", 32'(fault_cause_o),    32'(e.cause));
        cmpField(tag, "fault_pc",    fault_pc_o,            e.fpc);
        cmpField(tag, "halt",        32'(halt_o),           32'(e.halt));
        cmpField(tag, "fetch_count", fetch_count_o,         e.count);
    endtask

    function automatic logic [31:0] pickTarget();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 32'($urandom_range(0, 1023)) | 32'h1;
        if (r == 1) return (r[0] ? 32'hFFFF_FFFC : 32'd1024 + 32'($urandom_range(0, 63)) * 4);
        return 32'($urandom_range(0, 255)) * 4;
    endfunction

    initial begin
        obs_t z;
        logic rstn, stall, redir, err;
        logic [31:0] rpc;

        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0013 + 32'(i);
        mem[0] = W0; mem[1] = W1; mem[2] = 32'h0; mem[4] = W4; mem[255] = WL;
        m = mkObs(RESET_PC, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        z = mkObs(32'h0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

        tbl.push_back(mkVec(0, 0, 0, 0, 0, z));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(4, 1, W0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(8, 1, W1, 4, 0, 0, 0, 0, 2)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mkVec(1, 1, 0, 0, 0, mkObs(8, 1, W1, 4, 0, 0, 0, 0, 2)));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(8, 0, W1, 4, 0, 0, 0, 1, 2)));
        tbl.push_back(mkVec(1, 0, 1, 32'h10, 0, mkObs(8, 0, W1, 4, 0, 0, 0, 1, 2)));
        tbl.push_back(mkVec(0, 0, 0, 0, 0, z));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(4, 1, W0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkVec(1, 1, 1, 32'h10, 0, mkObs(32'h10, 0, W0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(32'h14, 1, W4, 32'h10, 0, 0, 0, 0, 2)));
        tbl.push_back(mkVec(1, 0, 1, 32'h6, 0, mkObs(32'h6, 0, W4, 32'h10, 0, 0, 0, 0, 2)));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(32'h6, 0, W4, 32'h10, 1, 2'b01, 32'h6, 0, 2)));
        tbl.push_back(mkVec(1, 0, 1, 32'h3FC, 0, mkObs(32'h6, 0, W4, 32'h10, 1, 2'b01, 32'h6, 0, 2)));
        tbl.push_back(mkVec(0, 0, 0, 0, 0, z));
        tbl.push_back(mkVec(1, 0, 1, 32'h3FC, 0, mkObs(32'h3FC, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(32'h400, 1, WL, 32'h3FC, 0, 0, 0, 0, 1)));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(32'h400, 0, WL, 32'h3FC, 1, 2'b10, 32'h400, 0, 1)));
        tbl.push_back(mkVec(0, 0, 0, 0, 0, z));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(4, 1, W0, 0, 0, 0, 0, 0, 1)));
        tbl.push_back(mkVec(1, 0, 0, 0, 1, mkObs(4, 0, W0, 0, 1, 2'b10, 4, 0, 1)));
        tbl.push_back(mkVec(0, 0, 0, 0, 0, z));
        tbl.push_back(mkVec(1, 0, 1, 32'h401, 0, mkObs(32'h401, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkVec(1, 0, 0, 0, 0, mkObs(32'h401, 0, 0, 0, 1, 2'b01, 32'h401, 0, 0)));

        $display("[TB] directed table: %0d vectors", tbl.size());
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rstn, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].err);
            checkOutput(tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Back-to-back redirects then a stalled bubble, checked against the model.
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput(m, "seq_reset");
        applyStimulus(1, 0, 1, 32'h20, 0);
        checkOutput(m, "seq_redir1");
        applyStimulus(1, 0, 1, 32'h40, 0);
        checkOutput(m, "seq_redir2");
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput(m, "seq_stall");
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput(m, "seq_fetch40");

        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 99) < 3) ? 32'h0 : ($urandom | 32'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput(m, "rand_reset");
        for (int i = 0; i < 600; i++) begin
            rstn = 1'b1;
            if ((m.fault || m.halt) && $urandom_range(0, 4) == 0) rstn = 1'b0;
            else if ($urandom_range(0, 99) == 0) rstn = 1'b0;
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 6) == 0);
            err   = ($urandom_range(0, 49) == 0);
            rpc   = pickTarget();
            applyStimulus(rstn, stall, redir, rpc, err);
            checkOutput(m, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
